seq_divider: RTL and testbench

Multi-cycle unsigned radix-2 restoring divider, the inverse companion to the adder/multiplier datapath blocks. Each cycle it produces one quotient bit with a trial subtraction: remainder minus divisor, with borrow-out deciding restore or keep. It sits beside the arithmetic units as a shared, non-pipelined resource. It uses a start/busy/done handshake.

---
 rtl/seq_divider.sv | 133 +++++++++++++
 tb/tb_seq_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned radix-2 restoring divider.
// One quotient bit per cycle; start/busy/done handshake.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t st, st_nxt;

  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] q_q;
  // R's top bit is always 0 between iterations (R < D), so only the
  // low WIDTH bits are stored; the trial works in WIDTH+1 bits.
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    cnt_q;

  logic             zdiv;
  logic             accept;
  logic             last;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] r_nxt;

  assign zdiv   = (divisor == '0);
  assign accept = start && (st != RUN);
  assign last   = (cnt_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= st_nxt;
  end

  // Next-state logic
  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE: begin
        if (start) st_nxt = zdiv ? DONE : RUN;
      end
      RUN: begin
        if (last) st_nxt = DONE;
      end
      DONE: begin
        if (start) st_nxt = zdiv ? DONE : RUN;
        else       st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (st)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // One restoring step: shift, trial subtract, keep or restore
  always_comb begin
    r_sh  = {r_q, q_q[WIDTH-1]};
    trial = r_sh - {1'b0, d_q};
    if (!trial[WIDTH]) begin
      r_nxt = trial[WIDTH-1:0];
      q_nxt = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      r_nxt = r_sh[WIDTH-1:0];
      q_nxt = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  // Iteration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      d_q   <= divisor;
      q_q   <= dividend;
      r_q   <= '0;
      cnt_q <= '0;
    end else if (st == RUN) begin
      q_q   <= q_nxt;
      r_q   <= r_nxt;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Result registers: loaded only when a result completes
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= zdiv;
      if (zdiv) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (st == RUN && last) begin
      quotient  <= q_nxt;
      remainder <= r_nxt;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and back-to-back checks
// for the sequential restoring divider.
module tb_seq_divider;

  localparam int W = 16;
  localparam int NR = 1000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int nchk = 0;
  int nerr = 0;

  int t, cyc, ndone, tdone, last_t;
  logic [W-1:0] ra [NR];
  logic [W-1:0] rb [NR];
  logic [W-1:0] gq, gr;
  logic [31:0]  prod;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input string tag,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [W-1:0] eq,
                         input logic [W-1:0] er,
                         input logic edz,
                         input int elat);
    int c;
    int nb;
    c = 0;
    nb = 0;
    dividend = a;
    divisor = b;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!done && c < 40) begin
      if (busy) nb++;
      step();
      c++;
    end
    check({tag, "_lat"}, c, elat);
    check({tag, "_busycnt"}, nb, elat);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
    check({tag, "_r"}, {16'd0, remainder}, {16'd0, er});
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edz});
    step();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", {16'd0, quotient}, 32'd0);
    check("rst_r", {16'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    step();

    run_div("basic", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, W);
    run_div("max_by_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, W);
    run_div("max_by_max", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, W);
    run_div("small", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, W);
    run_div("dbz", 16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1'b1, 0);
    run_div("after_dbz", 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, W);

    // Busy interlock: second start during iteration 5 is dropped
    dividend = 16'd100;
    divisor = 16'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    t = 0;
    repeat (4) begin
      step();
      t++;
    end
    dividend = 16'd50;
    divisor = 16'd5;
    start = 1'b1;
    step();
    t++;
    start = 1'b0;
    ndone = 0;
    tdone = -1;
    gq = '0;
    gr = '0;
    while (t < 40) begin
      if (done) begin
        ndone++;
        tdone = t;
        gq = quotient;
        gr = remainder;
      end
      step();
      t++;
    end
    check("lock_ndone", ndone, 1);
    check("lock_tdone", tdone, W);
    check("lock_q", {16'd0, gq}, 32'd14);
    check("lock_r", {16'd0, gr}, 32'd2);

    // Reset in the middle of an operation
    dividend = 16'd100;
    divisor = 16'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_q", {16'd0, quotient}, 32'd0);
    check("mrst_r", {16'd0, remainder}, 32'd0);
    step();
    check("mrst_idle", {30'd0, busy, done}, 32'd0);
    run_div("post_rst", 16'd81, 16'd9, 16'd9, 16'd0, 1'b0, W);

    // Back-to-back stream with start held high
    for (int i = 0; i < NR; i++) begin
      ra[i] = W'($urandom_range(0, 65535));
      if (i % 3 == 0) rb[i] = W'($urandom_range(1, 15));
      else            rb[i] = W'($urandom_range(1, 65535));
    end
    dividend = ra[0];
    divisor = rb[0];
    start = 1'b1;
    step();
    t = 0;
    last_t = 0;
    for (int i = 0; i < NR; i++) begin
      cyc = 0;
      while (!done && cyc < 40) begin
        step();
        t++;
        cyc++;
      end
      check("b2b_done", {31'd0, done}, 32'd1);
      check("b2b_q", {16'd0, quotient},
            {16'd0, ra[i] / rb[i]});
      check("b2b_r", {16'd0, remainder},
            {16'd0, ra[i] % rb[i]});
      prod = 32'(quotient) * 32'(rb[i]) + 32'(remainder);
      check("b2b_inv", prod, {16'd0, ra[i]});
      check("b2b_rlt", {31'd0, remainder < rb[i]}, 32'd1);
      if (i > 0) check("b2b_gap", t - last_t, W + 1);
      last_t = t;
      if (i < NR - 1) begin
        dividend = ra[i + 1];
        divisor = rb[i + 1];
      end else begin
        start = 1'b0;
      end
      step();
      t++;
    end
    step();
    check("end_idle", {30'd0, busy, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
